joy_move_sequencer: RTL
=======================

Name: joy_move_sequencer

Overview:
- Converts the 3-bit joystick direction code into discrete one-shot move commands for the 2048 board engine.
- Qualifies each direction over several sample strobes, issues one move per push through a req/ack handshake, and requires the stick to return to centre before it re-arms.
- Optional auto-repeat while a direction is held.
- Sits between the joystick direction decoder and the board-update logic.

Parameters:
- STABLE_CNT, 8'd20: number of consecutive matching samples needed to accept a direction (range 1..255).
- RELEASE_CNT, 8'd20: number of consecutive centre samples needed to re-arm (range 1..255).
- REPEAT_CNT, 8'd0: number of held samples after an acknowledged move before the move is re-issued; 0 disables auto-repeat.

Ports:
- clk  input  1  100 MHz system clock.
- rst  input  1  asynchronous, active-low reset.
- sample_en  input  1  one-cycle sample strobe (1 kHz tick); logic advances only on cycles where it is high.
- enable  input  1  game accepting moves; low means game over or paused.
- dir  input  3  joystick code: 000 up, 001 right, 010 down, 011 left, 1xx centre/invalid.
- move_ack  input  1  board engine has accepted the current move.
- move_req  output  1  move request; held high until acknowledged.
- move_dir  output  2  direction of the request (dir[1:0] encoding); stable while move_req is high.
- busy  output  1  high in every state except IDLE.
- move_count  output  16  number of acknowledged moves; saturates at 16'hFFFF.

Behaviour:
- Reset (rst low, asynchronous):
  - state = ARM, all counters = 0.
  - move_req = 0, move_dir = 2'b00, move_count = 0, busy = 1.
- A sample is a cycle with sample_en = 1.
- "centre" means dir[2] = 1. "valid" means dir[2] = 0.
- ARM:
  - A centre sample increments rel_cnt. A valid sample clears rel_cnt.
  - When rel_cnt reaches RELEASE_CNT and enable = 1, go to IDLE and clear rel_cnt.
  - If enable = 0, stay in ARM; counting continues but rel_cnt saturates at RELEASE_CNT.
- IDLE:
  - A valid sample with enable = 1 goes to QUALIFY, with cand = dir[1:0] and stb_cnt = 1.
  - If STABLE_CNT = 1, go directly to REQ instead.
  - enable = 0 goes to ARM.
- QUALIFY:
  - A sample with dir[1:0] = cand increments stb_cnt. When it reaches STABLE_CNT, go to REQ.
  - A different valid dir on a sample sets cand = dir[1:0] and stb_cnt = 1.
  - A centre sample goes to IDLE.
  - enable = 0 (checked on any cycle) goes to ARM.
- REQ:
  - move_req = 1 and move_dir = cand, both registered.
  - move_req rises on the clock edge after the qualifying sample, i.e. 1 cycle of latency.
  - sample_en, dir and enable are ignored; the request is never withdrawn except by reset.
  - On any cycle with move_ack = 1: drop move_req on the next edge, increment move_count (saturating), go to HOLD, clear hold_cnt.
  - An ack arriving in the same cycle move_req first goes high counts.
- move_ack outside REQ is ignored: no count change, no state change.
- HOLD:
  - A centre sample goes to ARM with rel_cnt = 1. If RELEASE_CNT = 1, go to IDLE directly (if enable = 1).
  - A sample with dir[1:0] = cand increments hold_cnt.
    - If REPEAT_CNT != 0 and hold_cnt reaches REPEAT_CNT with enable = 1, go to REQ and re-issue the same cand.
  - A different valid dir is ignored (the stick must centre first), and hold_cnt is cleared.
  - enable = 0 blocks repeat only; the return path via centre still applies.
- Counters are 8-bit and compared with ==. Reaching a count takes effect on that same sample.
- move_count wraps never; it holds at FFFF.
- Reset mid-request drops move_req immediately (asynchronous). The downstream engine must tolerate a vanished request.

Test Plan:
- Reset release with dir = 100 for 20 samples, then dir = 001 for 20 samples -> move_req rises 1 clk after the 20th 001 sample with move_dir = 01. Ack held 3 clks later -> move_req = 0, move_count = 1.
- In IDLE: dir = 000 for 10 samples, then 010 for 20 samples -> exactly one request, move_dir = 10, issued on the 20th 010 sample (the cand switch restarted the count).
- After an acked move, keep dir = 011 for 500 samples with REPEAT_CNT = 0 -> no further requests. Then centre for 19 samples and 011 for 20 -> no request (not re-armed). Then centre for 20 and 011 for 20 -> second request.
- With REPEAT_CNT = 50, hold 000 and ack every request immediately -> requests on samples 20, 70, 120; move_count = 3.
- enable = 0 during QUALIFY -> state ARM, no move_req. enable = 0 while in REQ -> move_req stays high until move_ack, then move_count increments.
- Assert rst low while move_req = 1 -> move_req = 0 asynchronously and move_count = 0. After release, a 001 push without 20 centre samples first -> no request.

Source files
------------

// File: rtl/joy_move_sequencer.sv
// Turns qualified joystick directions into one-shot move requests (req/ack) for the board engine.
// The stick must return to centre before it re-arms; optional auto-repeat while held.
module joy_move_sequencer #(
  parameter logic [7:0] STABLE_CNT  = 8'd20,
  parameter logic [7:0] RELEASE_CNT = 8'd20,
  parameter logic [7:0] REPEAT_CNT  = 8'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sample_en,
  input  logic        enable,
  input  logic [2:0]  dir,
  input  logic        move_ack,
  output logic        move_req,
  output logic [1:0]  move_dir,
  output logic        busy,
  output logic [15:0] move_count
);

  typedef enum logic [2:0] {ARM, IDLE, QUALIFY, REQ, HOLD} state_e;

  state_e      state_q, state_d;
  logic [7:0]  rel_cnt_q, rel_cnt_d;
  logic [7:0]  stb_cnt_q, stb_cnt_d;
  logic [7:0]  hold_cnt_q, hold_cnt_d;
  logic [1:0]  cand_q, cand_d;
  logic        move_req_q, move_req_d;
  logic [1:0]  move_dir_q, move_dir_d;
  logic        busy_q, busy_d;
  logic [15:0] move_count_q, move_count_d;

  logic centre, match;

  assign centre = dir[2];
  assign match  = (dir[1:0] == cand_q);

  always_comb begin
    state_d      = state_q;
    rel_cnt_d    = rel_cnt_q;
    stb_cnt_d    = stb_cnt_q;
    hold_cnt_d   = hold_cnt_q;
    cand_d       = cand_q;
    move_count_d = move_count_q;

    case (state_q)
      ARM: begin
        if (sample_en) begin
          if (centre) begin
            if (rel_cnt_q != RELEASE_CNT) rel_cnt_d = rel_cnt_q + 8'd1;
          end else begin
            rel_cnt_d = '0;
          end
        end
        // Saturated count leaves as soon as enable returns, even without a new sample.
        if (enable && (rel_cnt_d == RELEASE_CNT)) begin
          state_d   = IDLE;
          rel_cnt_d = '0;
        end
      end
      IDLE: begin
        if (!enable) begin
          state_d   = ARM;
          rel_cnt_d = '0;
        end else if (sample_en && !centre) begin
          cand_d    = dir[1:0];
          stb_cnt_d = 8'd1;
          state_d   = (STABLE_CNT == 8'd1) ? REQ : QUALIFY;
        end
      end
      QUALIFY: begin
        if (!enable) begin
          state_d   = ARM;
          rel_cnt_d = '0;
        end else if (sample_en) begin
          if (centre) begin
            state_d = IDLE;
          end else if (match) begin
            stb_cnt_d = stb_cnt_q + 8'd1;
            if (stb_cnt_d == STABLE_CNT) state_d = REQ;
          end else begin
            cand_d    = dir[1:0];
            stb_cnt_d = 8'd1;
          end
        end
      end
      REQ: begin
        if (move_ack) begin
          state_d    = HOLD;
          hold_cnt_d = '0;
          if (move_count_q != 16'hFFFF) move_count_d = move_count_q + 16'd1;
        end
      end
      HOLD: begin
        if (sample_en) begin
          if (centre) begin
            if ((RELEASE_CNT == 8'd1) && enable) begin
              state_d   = IDLE;
              rel_cnt_d = '0;
            end else begin
              state_d   = ARM;
              rel_cnt_d = 8'd1;
            end
          end else if (match) begin
            hold_cnt_d = hold_cnt_q + 8'd1;
            if ((REPEAT_CNT != 8'd0) && (hold_cnt_d == REPEAT_CNT) && enable) state_d = REQ;
          end else begin
            hold_cnt_d = '0;
          end
        end
      end
      default: state_d = ARM;
    endcase

    // Outputs are registered from the next state so they align with it.
    move_req_d = (state_d == REQ);
    move_dir_d = (state_d == REQ) ? cand_d : move_dir_q;
    busy_d     = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ARM;
      rel_cnt_q    <= '0;
      stb_cnt_q    <= '0;
      hold_cnt_q   <= '0;
      cand_q       <= '0;
      move_req_q   <= 1'b0;
      move_dir_q   <= '0;
      busy_q       <= 1'b1;
      move_count_q <= '0;
    end else begin
      state_q      <= state_d;
      rel_cnt_q    <= rel_cnt_d;
      stb_cnt_q    <= stb_cnt_d;
      hold_cnt_q   <= hold_cnt_d;
      cand_q       <= cand_d;
      move_req_q   <= move_req_d;
      move_dir_q   <= move_dir_d;
      busy_q       <= busy_d;
      move_count_q <= move_count_d;
    end
  end

  assign move_req   = move_req_q;
  assign move_dir   = move_dir_q;
  assign busy       = busy_q;
  assign move_count = move_count_q;

endmodule
